dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 8 +
 rtl/rr_select2.sv | 11 +
 rtl/dmem_arbiter.sv | 72 +++++++
 tb/tb_dmem_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, FSM encoding and port indices for the data-memory arbiter
package dmem_arbiter_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 64;
    localparam int P0 = 0;
    localparam int P1 = 1;
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
endpackage

// File: rtl/rr_select2.sv
// rr_select2: two-way round-robin selector; on a tie the port not served last wins
module rr_select2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant[P0] = req[P0] & (~req[P1] | last);
    assign grant[P1] = req[P1] & (~req[P0] | ~last);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for an external data memory, one access per two cycles
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    state_t     state;
    logic       last;
    logic [1:0] grant;

    rr_select2 u_sel (.req({req1, req0}), .last(last), .grant(grant));

    assign busy = (state != IDLE);

    // mem_addr/mem_wdata/mem_we double as the latched command registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            last      <= 1'b1;
        end else if (state == IDLE) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (|grant) begin
                state     <= ACCESS;
                gnt0      <= grant[P0];
                gnt1      <= grant[P1];
                last      <= grant[P1];
                mem_we    <= grant[P1] ? we1 : we0;
                mem_addr  <= grant[P1] ? addr1 : addr0;
                mem_wdata <= grant[P1] ? wdata1 : wdata0;
            end
        end else begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            mem_we  <= 1'b0;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (!mem_we) rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, timing, reset abort and command latching
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [63:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
    logic [63:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [63:0] mem [256];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 64'hA000 + 64'(i);
        #2;
        chk("reset_ctl", {59'd0, gnt0, gnt1, rvalid0, rvalid1, busy}, 64'd0);
        chk("reset_mem", {55'd0, mem_we, mem_addr}, 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_wdata", mem_wdata, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ctl", {58'd0, gnt0, gnt1, rvalid0, rvalid1, busy, mem_we}, 64'd0);
            chk("idle_rdata", rdata, 64'd0);
        end

        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 64'd9;
        tick();
        chk("wr_gnt", {62'd0, gnt0, gnt1}, 64'b10);
        chk("wr_memwe", {62'd0, mem_we, busy}, 64'b11);
        chk("wr_addr", {56'd0, mem_addr}, 64'h05);
        chk("wr_wdata", mem_wdata, 64'd9);
        chk("wr_no_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
        tick();
        req0 = 1'b0; we0 = 1'b0;
        chk("wr_rvalid", {60'd0, rvalid0, rvalid1, gnt0, busy}, 64'b1000);
        chk("wr_rdata_hold", rdata, 64'd0);
        tick();
        chk("wr_rvalid_gone", {62'd0, rvalid0, mem_we}, 64'd0);
        req0 = 1'b1; addr0 = 8'h05;
        tick();
        chk("rd_gnt", {61'd0, gnt0, gnt1, mem_we}, 64'b100);
        tick();
        req0 = 1'b0;
        chk("rd_rvalid", {62'd0, rvalid0, rvalid1}, 64'b10);
        chk("rd_rdata", rdata, 64'd9);
        tick();

        rst = 1'b1; #2; rst = 1'b0;
        chk("rst_rdata", rdata, 64'd0);
        req0 = 1'b1; addr0 = 8'h01; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        tick();
        chk("tie_first", {62'd0, gnt0, gnt1}, 64'b10);
        chk("tie_addr0", {56'd0, mem_addr}, 64'h01);
        tick();
        req0 = 1'b0;
        chk("tie_rv0", {62'd0, rvalid0, rvalid1}, 64'b10);
        chk("tie_rd0", rdata, 64'hA001);
        tick();
        chk("tie_second", {62'd0, gnt0, gnt1}, 64'b01);
        chk("tie_addr1", {56'd0, mem_addr}, 64'h02);
        tick();
        req1 = 1'b0;
        chk("tie_rv1", {62'd0, rvalid0, rvalid1}, 64'b01);
        chk("tie_rd1", rdata, 64'hA002);
        tick();

        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_gnt", {62'd0, gnt0, gnt1}, (k % 2 == 0) ? 64'b10 : 64'b01);
            chk("rr_gap", {62'd0, rvalid0, rvalid1}, 64'd0);
            tick();
            chk("rr_rvalid", {60'd0, rvalid0, rvalid1, gnt0, gnt1}, (k % 2 == 0) ? 64'b1000 : 64'b0100);
            chk("rr_rdata", rdata, (k % 2 == 0) ? 64'hA001 : 64'hA002);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 64'hFF;
        tick();
        chk("abort_pre", {61'd0, gnt0, mem_we, busy}, 64'b111);
        #2 rst = 1'b1;
        #1;
        chk("abort_now", {60'd0, gnt0, gnt1, mem_we, busy}, 64'd0);
        req0 = 1'b0; we0 = 1'b0;
        #1 rst = 1'b0;
        tick();
        chk("abort_no_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
        req0 = 1'b1; addr0 = 8'h10;
        tick();
        chk("abort_rd_gnt", {62'd0, gnt0, mem_we}, 64'b10);
        tick();
        req0 = 1'b0;
        chk("abort_rd_rv", {63'd0, rvalid0}, 64'd1);
        chk("abort_rd_data", rdata, 64'hA010);
        tick();

        req0 = 1'b1; addr0 = 8'h03;
        tick();
        chk("latch_gnt", {63'd0, gnt0}, 64'd1);
        addr0 = 8'h04;
        #1;
        chk("latch_addr", {56'd0, mem_addr}, 64'h03);
        tick();
        req0 = 1'b0;
        chk("latch_rv", {63'd0, rvalid0}, 64'd1);
        chk("latch_rdata", rdata, 64'hA003);
        tick();
        chk("final_idle", {59'd0, gnt0, gnt1, rvalid0, rvalid1, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
